// File: rtl/freq_switch_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM, registered press/release strobes.
// Optional auto-repeat of the press strobe while held is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module freq_switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic i_clock50,
    input  logic i_reset,
    input  logic i_button,
    output logic o_level,
    output logic o_pulse,
    output logic o_release
);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Idle pin level, so the synchronizer never shows a press straight out of reset.
    localparam logic RELEASED_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   btn_s;
    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   rep_hit_s;
    logic                   rep_hit_r;
    logic                   level_s;

    // Input synchronizer chain.
    always_ff @(posedge i_clock50) begin
        if (i_reset) begin
            sync_r <= {SYNC_STAGES{RELEASED_PIN}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_button};
        end
    end

    assign btn_s   = (ACTIVE_LOW != 0) ? ~sync_r[SYNC_STAGES-1] : sync_r[SYNC_STAGES-1];
    assign level_s = (state_r == ST_PRESSED) || (state_r == ST_WAIT_RELEASE);

    // Debounce next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rep_hit_s   = 1'b0;
        case (state_r)
            ST_RELEASED: begin
                if (btn_s) begin
                    state_nxt_s = ST_WAIT_PRESS;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_WAIT_PRESS: begin
                if (!btn_s) begin
                    state_nxt_s = ST_RELEASED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_nxt_s = ST_WAIT_RELEASE;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    if (cnt_r == REP_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
                        rep_hit_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
`else
                    cnt_nxt_s = CNT_ZERO;
`endif
                end
            end
            ST_WAIT_RELEASE: begin
                if (btn_s) begin
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_nxt_s = ST_RELEASED;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RELEASED;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and repeat-event registers.
    always_ff @(posedge i_clock50) begin
        if (i_reset) begin
            state_r   <= ST_RELEASED;
            cnt_r     <= CNT_ZERO;
            rep_hit_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            rep_hit_r <= rep_hit_s;
        end
    end

    // Strobes come from level edges, so a reset that drops o_level never produces a release.
    always_ff @(posedge i_clock50) begin
        if (i_reset) begin
            o_level   <= 1'b0;
            o_pulse   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_level   <= level_s;
            o_pulse   <= (level_s & ~o_level) | rep_hit_r;
            o_release <= ~level_s & o_level;
        end
    end

endmodule

// File: tb/tb_freq_switch_debounce.sv
// Directed bench for freq_switch_debounce with DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20.
module tb_freq_switch_debounce;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic level;
    logic pulse;
    logic release_s;

    int checks     = 0;
    int errors     = 0;
    int pulse_cnt  = 0;
    int rel_cnt    = 0;
    int p0;
    int r0;

    freq_switch_debounce #(
        .DEBOUNCE_CYCLES(8),
        .SYNC_STAGES    (2),
        .ACTIVE_LOW     (1),
        .REPEAT_CYCLES  (20)
    ) dut (
        .i_clock50(clk),
        .i_reset  (rst),
        .i_button (button),
        .o_level  (level),
        .o_pulse  (pulse),
        .o_release(release_s)
    );

    always #5 clk = ~clk;

    // Strobe counters sampled on the falling edge.
    always @(negedge clk) begin
        if (pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
        if (release_s === 1'b1) rel_cnt = rel_cnt + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b1;

        // Reset held for three cycles with the button released.
        tick(3);
        chk("reset_level", {31'd0, level}, 32'd0);
        chk("reset_pulse", {31'd0, pulse}, 32'd0);
        chk("reset_release", {31'd0, release_s}, 32'd0);
        rst = 1'b0;
        tick(50);
        chk("idle_pulses", pulse_cnt, 32'd0);
        chk("idle_releases", rel_cnt, 32'd0);

        // Clean press: pin low before edge 0, strobe after edge 10.
        p0 = pulse_cnt;
        button = 1'b0;
        tick(10);
        chk("press_e9_pulse", {31'd0, pulse}, 32'd0);
        chk("press_e9_level", {31'd0, level}, 32'd0);
        tick(1);
        chk("press_e10_pulse", {31'd0, pulse}, 32'd1);
        chk("press_e10_level", {31'd0, level}, 32'd1);
        tick(1);
        chk("press_e11_pulse", {31'd0, pulse}, 32'd0);
        chk("press_e11_level", {31'd0, level}, 32'd1);

        // Clean release, symmetric latency.
        r0 = rel_cnt;
        button = 1'b1;
        tick(10);
        chk("rel_e9_release", {31'd0, release_s}, 32'd0);
        chk("rel_e9_level", {31'd0, level}, 32'd1);
        tick(1);
        chk("rel_e10_release", {31'd0, release_s}, 32'd1);
        chk("rel_e10_level", {31'd0, level}, 32'd0);
        chk("rel_e10_pulse", {31'd0, pulse}, 32'd0);
        tick(1);
        chk("rel_e11_release", {31'd0, release_s}, 32'd0);
        chk("press_pulse_count", pulse_cnt - p0, 32'd1);
        chk("release_count", rel_cnt - r0, 32'd1);

        // Bounce: 5 low, 2 high, then steady low.
        tick(5);
        p0 = pulse_cnt;
        button = 1'b0;
        tick(5);
        button = 1'b1;
        tick(2);
        button = 1'b0;
        tick(10);
        chk("bounce_e9_pulse", {31'd0, pulse}, 32'd0);
        chk("bounce_no_early_pulse", pulse_cnt - p0, 32'd0);
        tick(1);
        chk("bounce_e10_pulse", {31'd0, pulse}, 32'd1);
        chk("bounce_e10_level", {31'd0, level}, 32'd1);
        tick(1);
        chk("bounce_e11_pulse", {31'd0, pulse}, 32'd0);
        chk("bounce_pulse_count", pulse_cnt - p0, 32'd1);

        // Reset while pressed: level drops, no release, re-qualified from scratch.
        r0 = rel_cnt;
        rst = 1'b1;
        tick(1);
        chk("midrst_level", {31'd0, level}, 32'd0);
        chk("midrst_pulse", {31'd0, pulse}, 32'd0);
        chk("midrst_release", {31'd0, release_s}, 32'd0);
        rst = 1'b0;
        p0 = pulse_cnt;
        tick(10);
        chk("midrst_e9_pulse", {31'd0, pulse}, 32'd0);
        chk("midrst_e9_level", {31'd0, level}, 32'd0);
        chk("midrst_no_release", rel_cnt - r0, 32'd0);
        tick(1);
        chk("midrst_e10_pulse", {31'd0, pulse}, 32'd1);
        chk("midrst_e10_level", {31'd0, level}, 32'd1);

        // Continued hold: repeat strobes at +30, +50, +70 only with auto-repeat.
        tick(19);
        chk("hold_e29_pulse", {31'd0, pulse}, 32'd0);
        tick(1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        chk("hold_e30_pulse", {31'd0, pulse}, 32'd1);
`else
        chk("hold_e30_pulse", {31'd0, pulse}, 32'd0);
`endif
        tick(20);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        chk("hold_e50_pulse", {31'd0, pulse}, 32'd1);
`else
        chk("hold_e50_pulse", {31'd0, pulse}, 32'd0);
`endif
        tick(20);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        chk("hold_e70_pulse", {31'd0, pulse}, 32'd1);
`else
        chk("hold_e70_pulse", {31'd0, pulse}, 32'd0);
`endif
        tick(1);
        chk("hold_e71_pulse", {31'd0, pulse}, 32'd0);
        chk("hold_level", {31'd0, level}, 32'd1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        chk("hold_pulse_count", pulse_cnt - p0, 32'd4);
`else
        chk("hold_pulse_count", pulse_cnt - p0, 32'd1);
`endif
        chk("hold_no_release", rel_cnt - r0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_switch_debounce.md
# freq_switch_debounce

Conditions a raw, bouncing board push-button into a clean single-cycle pulse in the 50 MHz domain. It sits directly upstream of the development clock generator and drives its frequency-select pulse input, so each physical press toggles the generated clock exactly once. It also exports the debounced level and a release pulse for other development-chassis logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized samples required to accept a change (20 ms at 50 MHz). Must be ≥ 2.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizer. Must be ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means `i_button`=0 is pressed; 0 means `i_button`=1 is pressed.
- `REPEAT_CYCLES`, default 12500000: auto-repeat period (250 ms). Used only when `DEBOUNCE_AUTOREPEAT_EN` is defined. Must be ≥ 2.
- `i_clock50`  in  1  50 MHz system clock; all logic is on its rising edge.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_button`  in  1  raw asynchronous push-button pin.
- `o_level`  out  1  debounced pressed level (1 = pressed).
- `o_pulse`  out  1  one-cycle strobe on accepted press; connects to the clock generator's frequency-select input.
- `o_release`  out  1  one-cycle strobe on accepted release.

## Operation
- **Synchronizer.** A `SYNC_STAGES`-deep flop chain samples `i_button`. The output is polarity-normalised to `s` (1 = pressed).
- **Reset values.** On reset, synchronizer flops take the *released* pin value (1 when `ACTIVE_LOW`=1), so no false press follows reset.
- **State machine**, states RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE:
  - RELEASED: if `s`=1, go to WAIT_PRESS with `cnt`=1. Otherwise stay, with `cnt`=0.
  - WAIT_PRESS: if `s`=0, return to RELEASED with `cnt`=0 (bounce rejected).
  - WAIT_PRESS: if `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1, go to PRESSED, set `o_level`=1, assert `o_pulse` for one cycle, and clear `cnt`.
  - WAIT_PRESS: otherwise `cnt`++.
  - PRESSED: if `s`=0, go to WAIT_RELEASE with `cnt`=1.
  - WAIT_RELEASE: mirror of WAIT_PRESS with `s`=0 as the stable value. Success clears `o_level` and asserts `o_release` for one cycle. Any `s`=1 returns to PRESSED.
- **Counter.** Width is `$clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1)`. The counter never wraps: it is cleared on every transition and saturates at its terminal compare.
- **Output registers.** All outputs are registered. `o_pulse` and `o_release` are never high in the same cycle, and neither is high for two consecutive cycles except under auto-repeat spacing, which is ≥ 2 cycles.
- **Reset mid-operation.** Reset forces RELEASED, `cnt`=0 and all outputs 0 on the next edge, with no release strobe. A button still held after reset is re-qualified from scratch.

## Timing
- **Reset.** `o_level`=0, `o_pulse`=0, `o_release`=0, state RELEASED.
- **Press latency.** Let the pin settle pressed before edge *k*. Then `s` rises after `SYNC_STAGES` edges, and `o_pulse` is high during exactly one cycle beginning `SYNC_STAGES`+`DEBOUNCE_CYCLES` edges after *k*. `o_level` rises on the same edge as `o_pulse`.
- **Release latency.** Symmetric to press latency, with `o_release` in place of `o_pulse`.
- **Bounce.** A glitch shorter than `DEBOUNCE_CYCLES` synchronized samples produces no output change and restarts qualification.
- **Back-to-back.** Minimum press-to-press pulse spacing is 2×`DEBOUNCE_CYCLES` cycles.

## Configuration
- **`DEBOUNCE_AUTOREPEAT_EN` defined.**
  - In PRESSED with `s`=1, `cnt` counts up. On reaching `REPEAT_CYCLES`-1, `o_pulse` is asserted for one cycle and `cnt` clears.
  - Repeat pulses occur every `REPEAT_CYCLES` cycles after the initial pulse while the button is held.
  - Entering WAIT_RELEASE discards the partial repeat count. A return to PRESSED restarts the repeat count from 0.
- **Not defined.** PRESSED holds `cnt`=0 and emits no further pulses. The repeat counter logic and the `REPEAT_CYCLES` width contribution are absent.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8, `SYNC_STAGES`=2, `ACTIVE_LOW`=1, `REPEAT_CYCLES`=20.
- **Reset.** Hold `i_reset`=1 for 3 cycles with `i_button`=1 → all outputs 0; no pulse for 50 cycles after release.
- **Clean press.** Drop `i_button` to 0 before edge 0 → `o_pulse` is high only in the cycle after edge 10, and `o_level`=1 from edge 10 on. Then set `i_button`=1 → `o_release` is a single-cycle strobe 10 edges later.
- **Bounce.** Set `i_button`=0 for 5 cycles, 1 for 2, then 0 steady → exactly one `o_pulse`, 10 edges after the final settle.
- **Reset mid-press.** Hold `i_button`=0, assert reset for 1 cycle while in PRESSED → `o_level` goes to 0 with no `o_release`, then a new `o_pulse` 10 edges after reset deasserts.
- **Autorepeat.** With `DEBOUNCE_AUTOREPEAT_EN` defined, hold `i_button`=0 for 70 cycles → pulses at 10, 30, 50, 70 edges after press. With the macro undefined → exactly one pulse.
